arbiter_memory_request_rr: RTL and testbench

- N-way round-robin arbiter that shares one cache/memory request port between N engine requesters.
- Each requester presents a MemoryPacket. The block grants one per cycle, converts it to a registered CacheRequest, and tracks outstanding reads.
- Returning CacheResponses are demultiplexed back to the originating requester.
- Provides a flush/drain sequence so the CU control path can quiesce the port before reconfiguration.

---
 rtl/arbiter_memory_request_rr_pkg.sv | 115 +++++++++++
 rtl/arbiter_rr_grant.sv | 32 +++
 rtl/arbiter_memory_request_rr.sv | 182 ++++++++++++++++++
 tb/tb_arbiter_memory_request_rr.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_memory_request_rr_pkg.sv
// Memory packet, cache request/response and arbiter types shared by the
// request arbiter and its grant logic.
package arbiter_memory_request_rr_pkg;

  localparam int M_AXI4_FE_ADDR_W = 32;
  localparam int M_AXI4_FE_DATA_W = 32;
  localparam int FIELD_W = 32;
  localparam int NUM_FIELDS = 2;
  localparam int MODULE_ID_W = 8;

  typedef enum logic [1:0] {
    CMD_INVALID,
    CMD_MEM_READ,
    CMD_MEM_WRITE,
    CMD_MEM_RESPONSE
  } type_memory_cmd;

  typedef enum logic [3:0] {
    ARB_IDLE  = 4'b0001,
    ARB_BUSY  = 4'b0010,
    ARB_DRAIN = 4'b0100,
    ARB_DONE  = 4'b1000
  } type_arbiter_state;

  typedef struct packed {
    logic [MODULE_ID_W-1:0] id_module;
    logic [MODULE_ID_W-1:0] id_engine;
  } route_id_t;

  typedef struct packed {
    route_id_t from;
    route_id_t to;
  } route_t;

  typedef struct packed {
    type_memory_cmd cmd;
  } subclass_t;

  typedef struct packed {
    logic [M_AXI4_FE_ADDR_W-1:0] offset;
    logic                        direction;
    logic [7:0]                  amount;
  } address_t;

  typedef struct packed {
    route_t    route;
    subclass_t subclass;
    address_t  address;
  } meta_t;

  typedef struct packed {
    logic [NUM_FIELDS-1:0][FIELD_W-1:0] field;
  } data_t;

  typedef struct packed {
    meta_t meta;
    data_t data;
  } payload_t;

  typedef struct packed {
    logic     valid;
    payload_t payload;
  } memory_packet_t;

  typedef struct packed {
    logic                          valid;
    logic [M_AXI4_FE_ADDR_W-1:0]   addr;
    logic [M_AXI4_FE_DATA_W-1:0]   wdata;
    logic [M_AXI4_FE_DATA_W/8-1:0] wstrb;
  } iob_req_t;

  typedef struct packed {
    logic     valid;
    iob_req_t iob;
    payload_t payload;
  } cache_request_t;

  typedef struct packed {
    logic [M_AXI4_FE_DATA_W-1:0] rdata;
  } iob_resp_t;

  typedef struct packed {
    logic      valid;
    iob_resp_t iob;
    payload_t  payload;
  } cache_response_t;

  typedef struct packed {
    logic full;
    logic prog_full;
  } fifo_state_signals_t;

  // Low tag bits of id_module carry the requester index back on the response.
  function automatic cache_request_t map_memory_packet_to_cache_request(
    input memory_packet_t         pkt,
    input logic [MODULE_ID_W-1:0] tag,
    input logic [MODULE_ID_W-1:0] tag_mask
  );
    cache_request_t r;
    logic [MODULE_ID_W-1:0] id;
    id = pkt.payload.meta.route.from.id_module;
    r.valid = pkt.valid;
    r.payload = pkt.payload;
    r.payload.meta.route.from.id_module = (id & ~tag_mask) | (tag & tag_mask);
    r.iob.valid = pkt.valid;
    if (pkt.payload.meta.address.direction)
      r.iob.addr = pkt.payload.meta.address.offset << pkt.payload.meta.address.amount;
    else
      r.iob.addr = pkt.payload.meta.address.offset >> pkt.payload.meta.address.amount;
    r.iob.wdata = pkt.payload.data.field[0];
    r.iob.wstrb = (pkt.payload.meta.subclass.cmd == CMD_MEM_WRITE) ? '1 : '0;
    return r;
  endfunction

endpackage

// File: rtl/arbiter_rr_grant.sv
// Round-robin grant: first valid index at or after ptr, wrapping modulo N.
// Emits a one-hot grant plus its encoded index; stall blanks the grant.
module arbiter_rr_grant #(
  parameter int  N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  input  logic            stall,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_valid
);

  always_comb begin
    int j;
    grant = '0;
    grant_idx = '0;
    grant_valid = 1'b0;
    // Walk from the farthest slot back so the nearest valid one wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (valid[j]) begin
        grant_idx = ID_W'(j);
        grant_valid = 1'b1;
      end
    end
    if (stall) grant_valid = 1'b0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/arbiter_memory_request_rr.sv
// Round-robin arbiter sharing one cache request port between N engines,
// with outstanding-read tracking, response demux and a flush/drain FSM.
module arbiter_memory_request_rr
  import arbiter_memory_request_rr_pkg::*;
#(
  parameter int  NUM_REQUESTERS  = 4,
  parameter int  MAX_OUTSTANDING = 16,
  localparam int ID_W  = $clog2(NUM_REQUESTERS),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      ap_clk,
  input  logic                      areset_n,
  input  memory_packet_t            req_in [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] req_ready_out,
  input  fifo_state_signals_t       fifo_cache_signals_in,
  output cache_request_t            cache_req_out,
  input  cache_response_t           cache_resp_in,
  output memory_packet_t            resp_out [NUM_REQUESTERS],
  input  logic                      flush_in,
  output logic                      flush_done_out,
  output logic [CNT_W-1:0]          outstanding_out,
  output logic                      error_out
);

  localparam logic [MODULE_ID_W-1:0] TAG_MASK =
    MODULE_ID_W'((1 << ID_W) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  type_arbiter_state state;
  logic [ID_W-1:0] rr_ptr;
  logic [CNT_W-1:0] outstanding;
  logic [NUM_REQUESTERS-1:0] req_valid;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic accept;
  logic stall;
  logic arb_open;
  logic issue_read;
  logic resp_v_in;
  logic resp_bad;
  logic [MODULE_ID_W-1:0] resp_id;
  memory_packet_t granted;
  cache_request_t req_map;
  cache_request_t req_data;
  logic req_v;
  payload_t resp_map;
  payload_t resp_data;
  logic [NUM_REQUESTERS-1:0] resp_v;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      req_valid[i] = req_in[i].valid;
  end

  assign arb_open = (state == ARB_IDLE) | (state == ARB_BUSY);

  // Reset gates the grant so ready reads 0 while areset_n is low.
  assign stall = !areset_n
               | fifo_cache_signals_in.full
               | fifo_cache_signals_in.prog_full
               | (outstanding == CNT_MAX)
               | !arb_open
               | flush_in;

  arbiter_rr_grant #(.N(NUM_REQUESTERS)) u_grant (
    .valid       (req_valid),
    .ptr         (rr_ptr),
    .stall       (stall),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (accept)
  );

  assign req_ready_out = grant;
  assign granted = req_in[grant_idx];
  assign issue_read = accept
    & (granted.payload.meta.subclass.cmd == CMD_MEM_READ);

  assign req_map = map_memory_packet_to_cache_request(
    granted, MODULE_ID_W'(grant_idx), TAG_MASK);

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) req_v <= 1'b0;
    else req_v <= accept;
  end

  always_ff @(posedge ap_clk) begin
    if (accept) req_data <= req_map;
  end

  always_comb begin
    cache_req_out = req_data;
    cache_req_out.valid = req_v;
    cache_req_out.iob.valid = req_v;
  end

  assign resp_v_in = cache_resp_in.valid;
  assign resp_id = cache_resp_in.payload.meta.route.from.id_module;
  assign resp_bad = resp_v_in
    & (resp_id >= MODULE_ID_W'(NUM_REQUESTERS));

  always_comb begin
    resp_map = cache_resp_in.payload;
    resp_map.data.field[0] = cache_resp_in.iob.rdata;
    resp_map.meta.subclass.cmd = CMD_MEM_RESPONSE;
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      resp_v <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++)
        resp_v[i] <= resp_v_in & (resp_id == MODULE_ID_W'(i));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (resp_v_in) resp_data <= resp_map;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      resp_out[i].valid = resp_v[i];
      resp_out[i].payload = resp_data;
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      outstanding <= '0;
      error_out <= 1'b0;
    end else begin
      if (resp_bad | (resp_v_in & (outstanding == '0)))
        error_out <= 1'b1;
      unique case ({issue_read, resp_v_in})
        2'b10: outstanding <= outstanding + CNT_W'(1);
        2'b01: if (outstanding != '0)
                 outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign outstanding_out = outstanding;

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQUESTERS - 1))
              ? '0 : grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= ARB_IDLE;
      flush_done_out <= 1'b0;
    end else begin
      flush_done_out <= 1'b0;
      unique case (state)
        ARB_IDLE:
          if (flush_in) state <= ARB_DRAIN;
          else if (accept) state <= ARB_BUSY;
        ARB_BUSY:
          if (flush_in) state <= ARB_DRAIN;
          else if (!(|req_valid) && outstanding == '0)
            state <= ARB_IDLE;
        ARB_DRAIN:
          if (outstanding == '0 && !req_v) begin
            state <= ARB_DONE;
            flush_done_out <= 1'b1;
          end
        ARB_DONE:
          if (!flush_in) state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_memory_request_rr.sv
// Directed + randomized bench for the round-robin memory request arbiter.
// A behavioural model predicts grants, requests, responses and counters.
module tb_arbiter_memory_request_rr;
  import arbiter_memory_request_rr_pkg::*;

  localparam int N = 4;
  localparam int MAXO = 16;
  localparam int CW = 5;
  localparam int S_IDLE = 0;
  localparam int S_BUSY = 1;
  localparam int S_DRAIN = 2;
  localparam int S_DONE = 3;

  logic ap_clk = 1'b0;
  logic areset_n = 1'b0;
  memory_packet_t req_in [N];
  logic [N-1:0] req_ready_out;
  fifo_state_signals_t fifo_sig;
  cache_request_t cache_req_out;
  cache_response_t cache_resp_in;
  memory_packet_t resp_out [N];
  logic flush_in = 1'b0;
  logic flush_done_out;
  logic [CW-1:0] outstanding_out;
  logic error_out;

  int checks = 0;
  int errors = 0;

  int m_ptr, m_cnt, m_st, last_gnt;
  bit m_err, m_rv, e_done;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0] e_wstrb;
  logic [5:0] e_idhi;
  int e_tag;
  logic [N-1:0] e_resp_v;

  arbiter_memory_request_rr #(
    .NUM_REQUESTERS(N),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .ap_clk(ap_clk),
    .areset_n(areset_n),
    .req_in(req_in),
    .req_ready_out(req_ready_out),
    .fifo_cache_signals_in(fifo_sig),
    .cache_req_out(cache_req_out),
    .cache_resp_in(cache_resp_in),
    .resp_out(resp_out),
    .flush_in(flush_in),
    .flush_done_out(flush_done_out),
    .outstanding_out(outstanding_out),
    .error_out(error_out)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic memory_packet_t new_pkt(input type_memory_cmd cmd);
    memory_packet_t p;
    p = '0;
    p.valid = 1'b1;
    p.payload.meta.subclass.cmd = cmd;
    p.payload.meta.address.offset = $urandom;
    p.payload.meta.address.direction = 1'($urandom_range(0, 1));
    p.payload.meta.address.amount = 8'($urandom_range(0, 7));
    p.payload.meta.route.from.id_module = 8'($urandom);
    p.payload.data.field[0] = $urandom;
    p.payload.data.field[1] = $urandom;
    return p;
  endfunction

  task automatic set_resp(input bit v, input int id, input logic [31:0] rd);
    cache_resp_in = '0;
    cache_resp_in.valid = v;
    cache_resp_in.iob.rdata = rd;
    cache_resp_in.payload.meta.route.from.id_module = 8'(id);
    cache_resp_in.payload.data.field[1] = $urandom;
  endtask

  task automatic m_reset();
    m_ptr = 0; m_cnt = 0; m_st = S_IDLE; m_err = 0;
    m_rv = 0; e_done = 0; e_resp_v = '0; last_gnt = -1;
  endtask

  function automatic int ref_grant();
    if (!areset_n || fifo_sig.full || fifo_sig.prog_full || m_cnt == MAXO
        || flush_in || !(m_st == S_IDLE || m_st == S_BUSY))
      return -1;
    for (int k = 0; k < N; k++)
      if (req_in[(m_ptr + k) % N].valid) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_update(input int g);
    bit anyv, rd, rv;
    int old_cnt;
    anyv = 0;
    for (int i = 0; i < N; i++) anyv |= req_in[i].valid;
    rd = (g >= 0) && req_in[(g < 0) ? 0 : g].payload.meta.subclass.cmd == CMD_MEM_READ;
    rv = cache_resp_in.valid;
    old_cnt = m_cnt;
    e_done = 0;
    case (m_st)
      S_IDLE: if (flush_in) m_st = S_DRAIN; else if (g >= 0) m_st = S_BUSY;
      S_BUSY: if (flush_in) m_st = S_DRAIN; else if (!anyv && old_cnt == 0) m_st = S_IDLE;
      S_DRAIN: if (old_cnt == 0 && !m_rv) begin m_st = S_DONE; e_done = 1; end
      default: if (!flush_in) m_st = S_IDLE;
    endcase
    m_rv = (g >= 0);
    if (g >= 0) begin
      memory_packet_t p;
      p = req_in[g];
      e_addr = p.payload.meta.address.direction
             ? p.payload.meta.address.offset << p.payload.meta.address.amount
             : p.payload.meta.address.offset >> p.payload.meta.address.amount;
      e_wdata = p.payload.data.field[0];
      e_wstrb = (p.payload.meta.subclass.cmd == CMD_MEM_WRITE) ? 4'hF : 4'h0;
      e_tag = g;
      e_idhi = p.payload.meta.route.from.id_module[7:2];
      m_ptr = (g + 1) % N;
    end
    e_resp_v = '0;
    if (rv) begin
      int id;
      id = int'(cache_resp_in.payload.meta.route.from.id_module);
      if (id < N) begin
        e_resp_v[id] = 1'b1;
        e_rdata = cache_resp_in.iob.rdata;
      end else m_err = 1;
      if (old_cnt == 0) m_err = 1;
    end
    if (rd && !rv) m_cnt++;
    else if (!rd && rv && m_cnt > 0) m_cnt--;
  endtask

  task automatic check_outputs();
    logic [N-1:0] rvv;
    chk("req_valid", cache_req_out.valid, m_rv);
    chk("iob_valid", cache_req_out.iob.valid, m_rv);
    if (m_rv) begin
      chk("addr", cache_req_out.iob.addr, e_addr);
      chk("wdata", cache_req_out.iob.wdata, e_wdata);
      chk("wstrb", cache_req_out.iob.wstrb, e_wstrb);
      chk("tag", cache_req_out.payload.meta.route.from.id_module[1:0], e_tag);
      chk("tag_hi", cache_req_out.payload.meta.route.from.id_module[7:2], e_idhi);
    end
    for (int i = 0; i < N; i++) rvv[i] = resp_out[i].valid;
    chk("resp_valid", rvv, e_resp_v);
    for (int i = 0; i < N; i++) begin
      if (e_resp_v[i]) begin
        chk("resp_data", resp_out[i].payload.data.field[0], e_rdata);
        chk("resp_cmd", resp_out[i].payload.meta.subclass.cmd, CMD_MEM_RESPONSE);
      end
    end
    chk("outstanding", outstanding_out, m_cnt);
    chk("error", error_out, m_err);
    chk("flush_done", flush_done_out, e_done);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    int g;
    #1;
    g = ref_grant();
    chk("ready", req_ready_out, (g < 0) ? 64'd0 : (64'd1 << g));
    last_gnt = g;
    model_update(g);
    @(posedge ap_clk);
    #1;
    check_outputs();
    @(negedge ap_clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) req_in[i] = '0;
  endtask

  task automatic refresh(input type_memory_cmd cmd);
    if (last_gnt >= 0) req_in[last_gnt] = new_pkt(cmd);
  endtask

  task automatic drain();
    clear_reqs();
    for (int t = 0; t < 64 && m_cnt > 0; t++) begin
      set_resp(1, $urandom_range(0, N - 1), $urandom);
      cycle();
    end
    set_resp(0, 0, 0);
    cycle();
    cycle();
    chk("drained", outstanding_out, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [N-1:0] rvv;
    for (int i = 0; i < N; i++) rvv[i] = resp_out[i].valid;
    chk({tag, "_ready"}, req_ready_out, 0);
    chk({tag, "_reqv"}, cache_req_out.valid, 0);
    chk({tag, "_respv"}, rvv, 0);
    chk({tag, "_cnt"}, outstanding_out, 0);
    chk({tag, "_err"}, error_out, 0);
    chk({tag, "_done"}, flush_done_out, 0);
  endtask

  initial begin
    int pulses;
    fifo_sig = '0;
    set_resp(0, 0, 0);
    for (int i = 0; i < N; i++) req_in[i] = new_pkt(CMD_MEM_WRITE);
    m_reset();
    #2;
    check_reset_outputs("reset");
    @(negedge ap_clk);
    @(negedge ap_clk);
    areset_n = 1'b1;

    // round robin with every requester valid: 0,1,2,3,0,1,2
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("rr_order", req_ready_out, 64'd1 << (i % N));
      cycle();
      refresh(CMD_MEM_WRITE);
    end

    // only requester 2 valid with pointer at 3: wraps to 2
    clear_reqs();
    req_in[2] = new_pkt(CMD_MEM_WRITE);
    req_in[2].payload.meta.address.offset = 32'h100;
    req_in[2].payload.meta.address.direction = 1'b0;
    req_in[2].payload.meta.address.amount = 8'd2;
    #1;
    chk("wrap_ready", req_ready_out, 4'b0100);
    cycle();
    chk("wrap_addr", cache_req_out.iob.addr, 32'h40);
    chk("wrap_tag", cache_req_out.payload.meta.route.from.id_module[1:0], 2);
    clear_reqs();
    cycle();
    cycle();

    // fill to MAX_OUTSTANDING reads
    req_in[0] = new_pkt(CMD_MEM_READ);
    for (int t = 0; t < 40 && m_cnt < MAXO; t++) begin
      cycle();
      refresh(CMD_MEM_READ);
    end
    chk("full_cnt", outstanding_out, MAXO);
    #1;
    chk("full_stall", req_ready_out, 0);
    set_resp(1, 0, $urandom);
    cycle();
    chk("resp_at_full", outstanding_out, MAXO - 1);
    set_resp(0, 0, 0);
    cycle();
    chk("resume", outstanding_out, MAXO);
    clear_reqs();

    // retire everything; one response carries 0xDEAD to requester 1
    for (int k = 0; k < MAXO; k++) begin
      set_resp(1, (k == 5) ? 1 : k % N, (k == 5) ? 32'hDEAD : $urandom);
      cycle();
      if (k == 5) begin
        chk("dead_valid", resp_out[1].valid, 1);
        chk("dead_data", resp_out[1].payload.data.field[0], 32'hDEAD);
        chk("dead_others", {resp_out[3].valid, resp_out[2].valid, resp_out[0].valid}, 0);
      end
    end
    set_resp(0, 0, 0);
    cycle();
    cycle();

    // flush with 3 reads in flight
    for (int i = 0; i < 3; i++) req_in[i] = new_pkt(CMD_MEM_READ);
    for (int t = 0; t < 3; t++) begin
      cycle();
      if (last_gnt >= 0) req_in[last_gnt] = '0;
    end
    chk("flush_pre_cnt", outstanding_out, 3);
    for (int i = 0; i < N; i++) req_in[i] = new_pkt(CMD_MEM_READ);
    flush_in = 1'b1;
    #1;
    chk("flush_block", req_ready_out, 0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      set_resp(1, k, $urandom);
      cycle();
    end
    set_resp(0, 0, 0);
    pulses = 0;
    for (int t = 0; t < 8; t++) begin
      cycle();
      if (flush_done_out) pulses++;
    end
    chk("flush_pulses", pulses, 1);
    flush_in = 1'b0;
    cycle();
    cycle();
    drain();

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        if (!req_in[i].valid && $urandom_range(0, 1) == 1)
          req_in[i] = new_pkt($urandom_range(0, 1) ? CMD_MEM_READ : CMD_MEM_WRITE);
      fifo_sig.prog_full = ($urandom_range(0, 7) == 0);
      if (m_cnt > 0 && $urandom_range(0, 2) == 0)
        set_resp(1, $urandom_range(0, N - 1), $urandom);
      else
        set_resp(0, 0, 0);
      cycle();
      if (last_gnt >= 0) begin
        if ($urandom_range(0, 1) == 1)
          req_in[last_gnt] = new_pkt($urandom_range(0, 1) ? CMD_MEM_READ : CMD_MEM_WRITE);
        else
          req_in[last_gnt] = '0;
      end
    end
    fifo_sig = '0;
    drain();

    // out-of-range response id is dropped and flags an error
    req_in[0] = new_pkt(CMD_MEM_READ);
    cycle();
    clear_reqs();
    cycle();
    set_resp(1, 5, 32'hBAD);
    cycle();
    set_resp(0, 0, 0);
    chk("bad_id_err", error_out, 1);
    cycle();

    // asynchronous reset mid-burst
    for (int i = 0; i < N; i++) req_in[i] = new_pkt(CMD_MEM_READ);
    for (int t = 0; t < 3; t++) begin
      cycle();
      refresh(CMD_MEM_READ);
    end
    #2;
    areset_n = 1'b0;
    m_reset();
    #1;
    check_reset_outputs("midreset");
    @(negedge ap_clk);
    areset_n = 1'b1;
    #1;
    chk("post_reset_grant", req_ready_out, 4'b0001);
    cycle();
    clear_reqs();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
